// File: rtl/io_map_pkg.sv
// IO bus address map and STATUS bit layout for the operator IO responder.
// Shared with CPU test programs and the PDU.
package io_map_pkg;

  localparam logic [7:0] IO_OUT    = 8'h00;
  localparam logic [7:0] IO_STATUS = 8'h04;
  localparam logic [7:0] IO_IN     = 8'h08;
  localparam logic [7:0] IO_CYCLE  = 8'h10;

  localparam int unsigned ST_IN_FULL  = 0;
  localparam int unsigned ST_OVERRUN  = 1;
  localparam int unsigned ST_OUT_BUSY = 2;
  localparam int unsigned ST_OUT_DROP = 3;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_OUT,
    SEL_STATUS,
    SEL_IN,
    SEL_CYCLE
  } io_sel_e;

  // Exact match only, so misaligned or unmapped addresses fall to SEL_NONE.
  function automatic io_sel_e io_decode(input logic [7:0] addr);
    case (addr)
      IO_OUT:    return SEL_OUT;
      IO_STATUS: return SEL_STATUS;
      IO_IN:     return SEL_IN;
      IO_CYCLE:  return SEL_CYCLE;
      default:   return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_rise.sv
// Three-flop synchronizer with a single-cycle rising-edge pulse.
// Chain resets to 1 so a level held high through reset never reads as an edge.
module sync_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pulse = s2_q & ~s3_q;

endmodule

// File: rtl/io_responder.sv
// Memory-mapped IO slave: operator input capture, LED output with display hold,
// and a free-running cycle counter on the CPU IO bus.
module io_responder
  import io_map_pkg::*;
#(
  parameter int unsigned HOLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [4:0]  in,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  output logic [4:0]  out0,
  output logic        ready,
  output logic [1:0]  check
);

  localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);

  logic [4:0]    out0_q, out0_d;
  logic [4:0]    in_data_q, in_data_d;
  logic          in_full_q, in_full_d;
  logic          overrun_q, overrun_d;
  logic          out_busy_q, out_busy_d;
  logic          out_drop_q, out_drop_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [31:0]   cycle_q, cycle_d;

  logic    cap;
  io_sel_e sel;
  logic    clr_full, clr_ovr, clr_drop;

  sync_rise u_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (valid),
    .pulse (cap)
  );

  assign sel      = io_decode(io_addr);
  assign clr_full = io_we && (sel == SEL_STATUS) && io_dout[ST_IN_FULL];
  assign clr_ovr  = io_we && (sel == SEL_STATUS) && io_dout[ST_OVERRUN];
  assign clr_drop = io_we && (sel == SEL_STATUS) && io_dout[ST_OUT_DROP];

  always_comb begin
    out0_d     = out0_q;
    in_data_d  = in_data_q;
    in_full_d  = in_full_q;
    overrun_d  = overrun_q;
    out_busy_d = out_busy_q;
    out_drop_d = out_drop_q;
    hold_d     = hold_q;

    // Clears are applied first so a same-cycle capture or overrun overrides them.
    if (clr_full) in_full_d  = 1'b0;
    if (clr_ovr)  overrun_d  = 1'b0;
    if (clr_drop) out_drop_d = 1'b0;

    if (cap) begin
      if (!in_full_q || clr_full) begin
        in_data_d = in;
        in_full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (out_busy_q) begin
      if (hold_q == '0) out_busy_d = 1'b0;
      else              hold_d     = hold_q - CW'(1);
    end

    if (io_we && (sel == SEL_OUT)) begin
      if (out_busy_q) begin
        out_drop_d = 1'b1;
      end else begin
        out0_d     = io_dout[4:0];
        out_busy_d = 1'b1;
        hold_d     = HOLD_LOAD;
      end
    end

    cycle_d = (io_we && (sel == SEL_CYCLE)) ? io_dout : cycle_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out0_q     <= '0;
      in_data_q  <= '0;
      in_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
      out_busy_q <= 1'b0;
      out_drop_q <= 1'b0;
      hold_q     <= '0;
      cycle_q    <= '0;
    end else begin
      out0_q     <= out0_d;
      in_data_q  <= in_data_d;
      in_full_q  <= in_full_d;
      overrun_q  <= overrun_d;
      out_busy_q <= out_busy_d;
      out_drop_q <= out_drop_d;
      hold_q     <= hold_d;
      cycle_q    <= cycle_d;
    end
  end

  always_comb begin
    io_din = '0;
    case (sel)
      SEL_OUT:    io_din = {27'b0, out0_q};
      SEL_STATUS: io_din = {28'b0, out_drop_q, out_busy_q, overrun_q, in_full_q};
      SEL_IN:     io_din = {27'b0, in_data_q};
      SEL_CYCLE:  io_din = cycle_q;
      default:    io_din = '0;
    endcase
  end

  assign out0  = out0_q;
  assign ready = ~in_full_q;
  assign check = {overrun_q, out_busy_q};

endmodule
